// File: rtl/ccr_cond_eval.sv
// Condition-code evaluator: registered CCR (C V N Z) plus a 3-state IDLE/EVAL/DONE request FSM.
// Optional taken-branch counter enabled by defining CCR_TAKEN_CNT_EN; debug state encoding IDLE=0 EVAL=1 DONE=2.
module ccr_cond_eval #(
  parameter int          CNT_W  = 8,
  parameter logic [3:0]  C_MASK = 4'b1000,
  parameter logic [3:0]  V_MASK = 4'b0100,
  parameter logic [3:0]  N_MASK = 4'b0010,
  parameter logic [3:0]  Z_MASK = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ccr_we,
  input  logic [3:0]       ccr_in,
  input  logic             req,
  input  logic [3:0]       cond,
  output logic             ready,
  output logic             valid,
  output logic             taken,
  output logic [3:0]       ccr_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  logic [3:0] cond_q;
  logic       cond_true;
  logic       c, v, n, z;

  assign fsm_state = state;

  // Evaluated during EVAL, so it sees any CCR write made on the accept edge
  // but not one made on the EVAL->DONE edge.
  always_comb begin
    cond_true = 1'b0;
    c = |(ccr_q & C_MASK);
    v = |(ccr_q & V_MASK);
    n = |(ccr_q & N_MASK);
    z = |(ccr_q & Z_MASK);
    case (cond_q)
      4'h0: cond_true = z;
      4'h1: cond_true = !z;
      4'h2: cond_true = c;
      4'h3: cond_true = !c;
      4'h4: cond_true = n;
      4'h5: cond_true = !n;
      4'h6: cond_true = v;
      4'h7: cond_true = !v;
      4'h8: cond_true = c && !z;
      4'h9: cond_true = !c || z;
      4'hA: cond_true = (n == v);
      4'hB: cond_true = (n != v);
      4'hC: cond_true = !z && (n == v);
      4'hD: cond_true = z || (n != v);
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Handshake: a request is accepted on any rising edge where ready && req;
  // valid is a single-cycle strobe two edges later and carries no back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      valid  <= 1'b0;
      taken  <= 1'b0;
      ccr_q  <= 4'b0000;
      cond_q <= 4'h0;
    end else begin
      if (ccr_we) ccr_q <= ccr_in;
      case (state)
        IDLE: begin
          if (req) begin
            state  <= EVAL;
            cond_q <= cond;
            ready  <= 1'b0;
          end
        end
        EVAL: begin
          state <= DONE;
          valid <= 1'b1;
          taken <= cond_true;
        end
        DONE: begin
          state <= IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef CCR_TAKEN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (state == EVAL && cond_true && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ccr_cond_eval.sv
// Directed bench for ccr_cond_eval: cycle-level reference model, per-cycle compare, literal anchors.
module tb_ccr_cond_eval;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef CCR_TAKEN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ccr_we = 1'b0;
  logic [3:0]       ccr_in = 4'h0;
  logic             req = 1'b0;
  logic [3:0]       cond = 4'h0;
  logic             ready, valid, taken;
  logic [3:0]       ccr_q;
  logic [CNT_W-1:0] taken_cnt;
  logic [1:0]       fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [0:0] exp_q[$];

  ccr_cond_eval #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ccr_we(ccr_we), .ccr_in(ccr_in), .req(req), .cond(cond),
    .ready(ready), .valid(valid), .taken(taken), .ccr_q(ccr_q), .taken_cnt(taken_cnt),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition table written directly from the C V N Z flag rules.
  function automatic bit cond_rule(input logic [3:0] cd, input logic [3:0] f);
    bit c, v, n, z;
    c = f[3]; v = f[2]; n = f[1]; z = f[0];
    case (cd)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c & !z;
      4'h9: return !c | z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z & (n == v);
      4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  // m_since: edges elapsed since the current request was accepted (0 = no request in flight).
  int         m_since = 0;
  logic [3:0] m_ccr   = 4'h0;
  logic [3:0] m_cond  = 4'h0;
  bit         m_taken = 1'b0;
  int         m_cnt   = 0;

  always @(posedge clk or posedge rst) begin
    logic [3:0] ccr_before;
    if (rst) begin
      m_since = 0; m_ccr = 4'h0; m_cond = 4'h0; m_taken = 1'b0; m_cnt = 0;
      exp_q.delete();
    end else begin
      ccr_before = m_ccr;
      if (ccr_we) m_ccr = ccr_in;
      if (m_since == 0) begin
        if (req) begin
          m_since = 1;
          m_cond  = cond;
        end
      end else if (m_since == 1) begin
        m_since = 2;
        m_taken = cond_rule(m_cond, ccr_before);
        if (CNT_EN && m_taken && m_cnt < CNT_MAX) m_cnt++;
        exp_q.push_back(m_taken);
      end else begin
        m_since = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [0:0] e;
    check("ready", ready, (m_since == 0));
    check("valid", valid, (m_since == 2));
    check("taken", taken, m_taken);
    check("ccr_q", ccr_q, m_ccr);
    check("taken_cnt", taken_cnt, m_cnt);
    check("fsm_state", fsm_state, m_since);
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_taken", taken, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic we, input logic [3:0] cv, input logic rq, input logic [3:0] cd);
    ccr_we = we; ccr_in = cv; req = rq; cond = cd;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic run_eval(input logic [3:0] cv, input logic [3:0] cd, output logic t);
    step(1'b1, cv, 1'b1, cd);
    check("acc_ready_low", ready, 0);
    idle();
    check("done_valid", valid, 1);
    t = taken;
    idle();
    check("idle_valid_low", valid, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic t;
    int   pulses;
    #1 rst = 1'b1;
    #2;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_ccr", ccr_q, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // CCR write and EQ request on the same edge: the write is seen.
    step(1'b1, 4'b0001, 1'b1, 4'h0);
    check("eq_evalcycle_valid", valid, 0);
    idle();
    check("eq_valid", valid, 1);
    check("eq_taken", taken, 1);
    check("eq_cnt", taken_cnt, CNT_EN ? 1 : 0);
    idle();
    idle();
    check("eq_taken_hold", taken, 1);

    run_eval(4'b1000, 4'h8, t); check("hi_c_only", t, 1);
    run_eval(4'b1001, 4'h8, t); check("hi_c_z", t, 0);
    run_eval(4'b0110, 4'hA, t); check("ge_n_v", t, 1);
    run_eval(4'b0010, 4'hB, t); check("lt_n_only", t, 1);
    run_eval(4'b0000, 4'hF, t); check("nv_never", t, 0);

    // Back-to-back requests with req held high.
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'h0, 1'b1, 4'hE);
      if (valid === 1'b1) pulses++;
    end
    check("al_pulses", pulses, 3);
    idle();

    // A write on the EVAL->DONE edge must not influence the result.
    step(1'b1, 4'b0000, 1'b1, 4'h4);
    step(1'b1, 4'b0010, 1'b0, 4'h0);
    check("mi_late_write_taken", taken, 0);
    check("mi_late_write_ccr", ccr_q, 4'b0010);
    idle();

    // Asynchronous reset while in EVAL.
    step(1'b0, 4'h0, 1'b1, 4'hE);
    rst = 1'b1;
    #1;
    check("arst_ready", ready, 1);
    check("arst_valid", valid, 0);
    check("arst_taken", taken, 0);
    check("arst_ccr", ccr_q, 0);
    check("arst_cnt", taken_cnt, 0);
    #1 rst = 1'b0;
    idle();
    check("arst_no_strobe", valid, 0);
    idle();
    check("arst_no_strobe2", valid, 0);
    run_eval(4'b0000, 4'hE, t); check("arst_next_req", t, 1);

    // Saturation of the 2-bit counter.
    pulse_reset();
    run_eval(4'h0, 4'hE, t); check("sat_cnt1", taken_cnt, CNT_EN ? 1 : 0);
    run_eval(4'h0, 4'hE, t); check("sat_cnt2", taken_cnt, CNT_EN ? 2 : 0);
    run_eval(4'h0, 4'hE, t); check("sat_cnt3", taken_cnt, CNT_EN ? 3 : 0);
    run_eval(4'h0, 4'hE, t); check("sat_cnt4", taken_cnt, CNT_EN ? 3 : 0);

    idle();
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ccr_cond_eval.md
CCR_COND_EVAL -- requirements
Module: ccr_cond_eval

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the taken-branch counter.
REQ-002 SHALL have parameters C_MASK='b1000, V_MASK='b0100, N_MASK='b0010, Z_MASK='b0001; CCR bit order is [3:0] = C V N Z.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ccr_we  input  1  load ccr_in into the internal CCR register.
REQ-006 SHALL have port ccr_in  input  4  CCR value produced by an ALU op (C V N Z).
REQ-007 SHALL have port req  input  1  evaluation request.
REQ-008 SHALL have port cond  input  4  condition code to evaluate.
REQ-009 SHALL have port ready  output  1  block accepts req this cycle.
REQ-010 SHALL have port valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port taken  output  1  condition result.
REQ-012 SHALL have port ccr_q  output  4  current registered CCR.
REQ-013 SHALL have port taken_cnt  output  CNT_W  count of taken results.

Function
REQ-014 ccr_q SHALL load ccr_in on any clock edge with ccr_we=1, in every FSM state.
REQ-015 FSM SHALL have states IDLE, EVAL, DONE; ready=1 only in IDLE, valid=1 only in DONE.
REQ-016 IDLE->EVAL on an edge with req=1; cond SHALL be latched on that edge; req is ignored in EVAL and DONE.
REQ-017 EVAL->DONE unconditionally; on that edge taken SHALL be computed from latched cond and the ccr_q value present during the EVAL cycle (a write on the accept edge is therefore included; a write on the EVAL->DONE edge is not).
REQ-018 DONE->IDLE unconditionally; latency accept edge to valid high is two edges; throughput one request per 3 cycles.
REQ-019 taken SHALL hold its value after valid drops until the next EVAL->DONE edge.
REQ-020 Condition encoding: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-021 taken_cnt SHALL increment by 1 on each EVAL->DONE edge producing taken=1, saturating at all-ones (no wrap).

Reset
REQ-022 rst=1 SHALL immediately, independent of clk, force state IDLE, ready=1, valid=0, taken=0, ccr_q=0, taken_cnt=0, latched cond=0.
REQ-023 Reset mid-operation (EVAL or DONE) SHALL abort the request with no valid strobe and no counter update.
REQ-024 After rst deasserts, the first edge SHALL behave as a normal IDLE edge (req accepted, ccr_we honoured).

Configuration
REQ-025 Macro CCR_TAKEN_CNT_EN SHALL gate the counter: defined -> REQ-021 behaviour; undefined -> no counter register, taken_cnt tied to 0, all other behaviour identical.

Verification
REQ-026 Reset then ccr_we=1, ccr_in=0001, req=1 cond=0 (EQ) same edge -> valid high two edges later, taken=1, taken_cnt=1.
REQ-027 ccr_q=1000, cond=8 (HI) -> taken=1; ccr_q=1001, cond=8 -> taken=0; ccr_q=0110, cond=A (GE) -> taken=1.
REQ-028 req held high continuously with cond=E -> valid pulses every 3rd cycle, ready low during EVAL/DONE, taken_cnt +1 per pulse.
REQ-029 Accept cond=4 with ccr_q=0000, then ccr_we=1 ccr_in=0010 on EVAL->DONE edge -> taken=0, ccr_q=0010 afterwards.
REQ-030 rst pulsed between clock edges while in EVAL -> outputs at reset values immediately, no valid strobe, next req served normally.
REQ-031 With CCR_TAKEN_CNT_EN and CNT_W=2, four cond=E requests -> taken_cnt 1,2,3,3; without macro -> taken_cnt stays 0.
